// File: rtl/ghash_engine.sv
// ghash_engine: sequential GHASH for AES-GCM.
//   Folds each accepted 128-bit block into Y = (Y xor X) * H over GF(2^128),
//   using a digit-serial multiplier (DIGIT bits of X per cycle, 128/DIGIT cycles).
//   The final Y of a message is presented on a valid/ready output.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   h_load, h_in        load hash subkey H (IDLE only)
//   init                clear accumulator Y (IDLE only)
//   in_valid/in_ready   input block handshake, in_data = X_i, in_last = final block
//   out_valid/out_ready result handshake, out_tag = Y
//   busy                high in MUL and OUT
module ghash_engine #(
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         h_load,
  input  logic [127:0] h_in,
  input  logic         init,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_tag,
  output logic         busy
);

  localparam int           STEPS     = 128 / DIGIT;
  localparam logic [6:0]   LAST_STEP = 7'(STEPS - 1);
  // GCM reflected bit order: R = 11100001 || 0^120
  localparam logic [127:0] R         = {8'hE1, 120'b0};

  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

  state_t       state_q, state_d;
  logic [127:0] h_q, h_d, y_q, y_d, x_q, x_d, z_q, z_d, v_q, v_d;
  logic [6:0]   cnt_q, cnt_d;
  logic         last_q, last_d;

  logic [127:0] z_step, v_step, x_step;
  logic         final_step;

  assign final_step = (cnt_q == LAST_STEP);

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      y_q     <= '0;
      x_q     <= '0;
      z_q     <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      y_q     <= y_d;
      x_q     <= x_d;
      z_q     <= z_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MUL;
      MUL:     if (final_step) state_d = last_q ? OUT : IDLE;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: DIGIT shift-and-add iterations unrolled per cycle, X consumed MSB-first
  always_comb begin
    h_d    = h_q;
    y_d    = y_q;
    x_d    = x_q;
    z_d    = z_q;
    v_d    = v_q;
    cnt_d  = cnt_q;
    last_d = last_q;

    z_step = z_q;
    v_step = v_q;
    x_step = x_q;
    for (int i = 0; i < DIGIT; i++) begin
      if (x_step[127]) z_step = z_step ^ v_step;
      v_step = v_step[0] ? ((v_step >> 1) ^ R) : (v_step >> 1);
      x_step = x_step << 1;
    end

    case (state_q)
      IDLE: begin
        if (h_load) h_d = h_in;
        if (init)   y_d = '0;
        // Accepted block uses the pre-update H and Y even if h_load/init coincide
        if (in_valid) begin
          x_d    = in_data ^ y_q;
          v_d    = h_q;
          z_d    = '0;
          cnt_d  = '0;
          last_d = in_last;
        end
      end
      MUL: begin
        z_d   = z_step;
        v_d   = v_step;
        x_d   = x_step;
        cnt_d = cnt_q + 7'd1;
        if (final_step) y_d = z_step;
      end
      OUT: begin
        // Auto-clear so the next message starts from zero without an init
        if (out_ready) y_d = '0;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    busy      = (state_q == MUL) || (state_q == OUT);
  end

  assign out_tag = y_q;

endmodule

// File: tb/tb_ghash_engine.sv
module tb_ghash_engine;

  localparam logic [127:0] ONE   = {1'b1, 127'b0};
  localparam logic [127:0] ID_X  = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] BLK_A = 128'hffff0000000000000000000000000000;
  localparam logic [127:0] BLK_B = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
  localparam logic [127:0] A_X_B = 128'hf0f00f0f0f0f0f0f0f0f0f0f0f0f0f0f;
  localparam logic [127:0] H_TC2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C_TC2 = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] Y1TC2 = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] LEN2  = 128'h00000000000000000000000000000080;
  localparam logic [127:0] GHTC2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] BLK_D = 128'hdeadbeef00112233cafef00d44556677;
  localparam logic [127:0] BLK_E = 128'h13579bdf2468ace00fedcba987654321;
  localparam logic [127:0] JUNK  = 128'ha5a5a5a55a5a5a5ac3c3c3c33c3c3c3c;

  logic                  clk = 1'b0;
  logic                  rst_n;
  // index 0: DIGIT=1, index 1: DIGIT=8
  logic [1:0]            h_load, init, in_valid, in_last, out_ready;
  logic [1:0]            in_ready, out_valid, busy;
  logic [1:0][127:0]     h_in, in_data, out_tag;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ghash_engine #(.DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .h_load(h_load[0]), .h_in(h_in[0]), .init(init[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_tag(out_tag[0]), .busy(busy[0])
  );

  ghash_engine #(.DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .h_load(h_load[1]), .h_in(h_in[1]), .init(init[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_tag(out_tag[1]), .busy(busy[1])
  );

  function automatic int n_of(input int d);
    return (d == 0) ? 128 : 16;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    h_load = '0; init = '0; in_valid = '0; in_last = '0; out_ready = '0;
    h_in = '0; in_data = '0;
  endtask

  task automatic load_h_init(input int d, input logic [127:0] h);
    h_in[d] = h; h_load[d] = 1'b1; init[d] = 1'b1;
    step();
    h_load[d] = 1'b0; init[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [127:0] data, input logic last);
    in_data[d] = data; in_last[d] = last; in_valid[d] = 1'b1;
    step();
    in_valid[d] = 1'b0; in_last[d] = 1'b0;
  endtask

  // Count samples with in_ready low until it rises (bounded)
  task automatic wait_idle(input int d, output int low_cnt);
    low_cnt = 0;
    while (!in_ready[d] && low_cnt < 400) begin
      low_cnt++;
      step();
    end
  endtask

  // Capture out_tag once out_valid is seen, then complete the handshake
  task automatic take_out(input int d, output logic [127:0] tag);
    tag = 'x;
    for (int i = 0; i < 400; i++) begin
      if (out_valid[d]) begin
        tag = out_tag[d];
        break;
      end
      step();
    end
    if (tag !== 'x) begin
      out_ready[d] = 1'b1;
      step();
      out_ready[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int d = 0; d < 2; d++) begin
        h_in[d] = rnd128(); in_data[d] = rnd128();
      end
      h_load = 2'($urandom); init = 2'($urandom); in_valid = 2'($urandom);
      in_last = 2'($urandom); out_ready = 2'($urandom);
      step();
    end
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if ({in_ready[d], out_valid[d], busy[d]} !== 3'b100)
        $display("FAIL reset_ctl[%0d]: got rdy/ov/busy=%b want 100", d, {in_ready[d], out_valid[d], busy[d]});
      else n_pass++;
      n_total++;
      if (out_tag[d] !== '0) $display("FAIL reset_tag[%0d]: got %h want 0", d, out_tag[d]);
      else n_pass++;
    end
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_mul(input int d);
    int lc;
    load_h_init(d, ONE);
    send(d, BLK_D, 1'b0);
    wait_idle(d, lc);
    send(d, BLK_E, 1'b0);
    step(); step();
    n_total++;
    if (!(busy[d] === 1'b1 && out_tag[d] === BLK_D))
      $display("FAIL pre_reset_mul[%0d]: busy=%b tag=%h want busy=1 tag=%h", d, busy[d], out_tag[d], BLK_D);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({in_ready[d], out_valid[d], busy[d]} !== 3'b100 || out_tag[d] !== '0)
      $display("FAIL reset_mid_mul[%0d]: rdy/ov/busy=%b tag=%h want 100 tag=0",
               d, {in_ready[d], out_valid[d], busy[d]}, out_tag[d]);
    else n_pass++;
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_identity(input int d);
    int lat;
    logic [127:0] tag;
    load_h_init(d, ONE);
    in_data[d] = ID_X; in_last[d] = 1'b1; in_valid[d] = 1'b1;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin in_valid[d] = 1'b0; in_last[d] = 1'b0; end
      if (out_valid[d]) break;
    end
    n_total++;
    if (lat !== n_of(d) + 1) $display("FAIL identity_latency[%0d]: got %0d want %0d", d, lat, n_of(d) + 1);
    else n_pass++;
    take_out(d, tag);
    n_total++;
    if (tag !== ID_X) $display("FAIL identity_tag[%0d]: got %h want %h", d, tag, ID_X);
    else n_pass++;
  endtask

  task automatic test_accumulate(input int d);
    int lc;
    logic [127:0] tag;
    load_h_init(d, ONE);
    send(d, BLK_A, 1'b0);
    wait_idle(d, lc);
    n_total++;
    if (lc !== n_of(d)) $display("FAIL accum_ready_gap[%0d]: got %0d want %0d", d, lc, n_of(d));
    else n_pass++;
    send(d, BLK_B, 1'b1);
    take_out(d, tag);
    n_total++;
    if (tag !== A_X_B) $display("FAIL accum_tag[%0d]: got %h want %h", d, tag, A_X_B);
    else n_pass++;
  endtask

  task automatic test_nist_tc2(input int d);
    int lc;
    logic [127:0] tag;
    load_h_init(d, H_TC2);
    send(d, C_TC2, 1'b0);
    wait_idle(d, lc);
    n_total++;
    if (out_tag[d] !== Y1TC2) $display("FAIL tc2_y1[%0d]: got %h want %h", d, out_tag[d], Y1TC2);
    else n_pass++;
    send(d, LEN2, 1'b1);
    take_out(d, tag);
    n_total++;
    if (tag !== GHTC2) $display("FAIL tc2_ghash[%0d]: got %h want %h", d, tag, GHTC2);
    else n_pass++;
  endtask

  task automatic test_backpressure(input int d);
    int waitc;
    logic stable;
    logic [127:0] tag;
    load_h_init(d, ONE);
    send(d, BLK_D, 1'b1);
    waitc = 0;
    while (!out_valid[d] && waitc < 400) begin waitc++; step(); end
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid[d] = 1'b1; in_data[d] = JUNK; in_last[d] = c[0];
      if (!(out_valid[d] === 1'b1 && out_tag[d] === BLK_D)) stable = 1'b0;
      step();
    end
    in_valid[d] = 1'b0; in_last[d] = 1'b0;
    n_total++;
    if (!(stable && out_valid[d] === 1'b1 && out_tag[d] === BLK_D))
      $display("FAIL bp_stable[%0d]: ov=%b tag=%h want ov=1 tag=%h", d, out_valid[d], out_tag[d], BLK_D);
    else n_pass++;
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    n_total++;
    if (!(out_tag[d] === '0 && in_ready[d] === 1'b1 && out_valid[d] === 1'b0))
      $display("FAIL bp_autoclear[%0d]: tag=%h rdy=%b ov=%b want tag=0 rdy=1 ov=0",
               d, out_tag[d], in_ready[d], out_valid[d]);
    else n_pass++;
    send(d, BLK_E, 1'b1);
    take_out(d, tag);
    n_total++;
    if (tag !== BLK_E) $display("FAIL bp_next_msg[%0d]: got %h want %h", d, tag, BLK_E);
    else n_pass++;
  endtask

  task automatic pulse_controls(input int d);
    h_in[d] = ONE; h_load[d] = 1'b1; init[d] = 1'b1;
    in_data[d] = JUNK; in_valid[d] = 1'b1; in_last[d] = 1'b1;
    step();
    h_load[d] = 1'b0; init[d] = 1'b0; in_valid[d] = 1'b0; in_last[d] = 1'b0;
  endtask

  task automatic test_ignored_controls(input int d);
    int lc;
    logic [127:0] tag;
    logic extra;
    load_h_init(d, H_TC2);
    send(d, C_TC2, 1'b0);
    step(); step();
    pulse_controls(d);
    wait_idle(d, lc);
    n_total++;
    if (out_tag[d] !== Y1TC2) $display("FAIL ign_y1[%0d]: got %h want %h", d, out_tag[d], Y1TC2);
    else n_pass++;
    send(d, LEN2, 1'b1);
    step(); step();
    pulse_controls(d);
    take_out(d, tag);
    n_total++;
    if (tag !== GHTC2) $display("FAIL ign_ghash[%0d]: got %h want %h", d, tag, GHTC2);
    else n_pass++;
    extra = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) extra = 1'b1;
      step();
    end
    n_total++;
    if (extra) $display("FAIL ign_block_count[%0d]: engine active after message, want idle", d);
    else n_pass++;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    for (int d = 0; d < 2; d++) begin
      test_reset_mid_mul(d);
      test_identity(d);
      test_accumulate(d);
      test_nist_tc2(d);
      test_backpressure(d);
      test_ignored_controls(d);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
